dsp_read_port: RTL and testbench
================================

# dsp_read_port

Host-facing read side of the DSP mailbox on the CT2960 riser. Buffers bytes produced by the DSP core in a small FIFO and returns them to the ISA host on I/O reads of the read-data port (base+0x0A). It also answers the read-status port (base+0x0E) with a data-available flag. It is the counterpart of the host write path, which latches command bytes into the DSP on active-low load strobes.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, 2..64.
- `WIDTH`, 8: data width; fixed at 8 for ISA use.

Ports:
- `clk` in 1: system clock, at least 8 MHz.
- `reset` in 1: asynchronous, active-low; clears all state.
- `wr_data` in WIDTH: byte from the DSP core.
- `wr_n` in 1: active-low push strobe, sampled each clk.
- `clr_n` in 1: active-low synchronous flush, issued by the DSP reset sequence.
- `ior_n` in 1: ISA IOR#, asynchronous to clk.
- `sel_data` in 1: decode hit for the read-data port; stable before `ior_n` falls.
- `sel_status` in 1: decode hit for the read-status port.
- `data_out` out WIDTH: value driven to SD[7:0].
- `data_oe` out 1: active-high enable for the SD bus transceiver.
- `empty` out 1: FIFO empty.
- `full` out 1: FIFO full.
- `level` out clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `overflow` out 1: sticky; set when a push is dropped.

## Operation
- **Reset values:** `data_out`=0x00, `data_oe`=0, `empty`=1, `full`=0, `level`=0, `overflow`=0, last-byte register=0x00.
- **IOR# synchronisation:** `ior_n` passes through a 2-flop synchroniser, then an edge detector.
- **Falling edge of synced IOR#:** `sel_data`/`sel_status` are latched into a 2-bit `cycle_sel`.
- **Read-data cycle:** `data_out` = FIFO head if not empty, otherwise the last-byte register (repeat of the last popped byte).
- **Read-status cycle:** `data_out` = {~empty, 7'h7F}.
- **No select latched:** `data_oe` stays 0 for the whole strobe.
- **Rising edge of synced IOR#:** `data_oe` deasserts.
  - If the cycle was a read-data cycle and the FIFO is not empty, the head is popped and copied into the last-byte register.
  - A pop while empty does nothing.
- **Push:** on `wr_n`=0 and not full, `wr_data` is written at the tail.
- **Push while full:** the byte is dropped and `overflow` is set.
- **Simultaneous push and pop:** both occur and `level` is unchanged. A push while full that coincides with a pop is accepted.
- **Flush:** `clr_n`=0 empties the FIFO and clears `overflow` and the last-byte register. It has priority over a same-cycle push and pop.
  - `data_oe` and `cycle_sel` are not affected, so an in-progress host read completes.
- **Pointers:** clog2(DEPTH)-bit read/write pointers wrap modulo DEPTH. `full`/`empty` are derived from `level`.

## Timing
- Bus-side state machine: IDLE -> DRIVE on the synced falling edge; DRIVE -> IDLE on the synced rising edge.
- `data_oe` and `data_out` are valid at the 3rd clk rising edge after `ior_n` falls: 2 synchroniser edges plus 1 registered edge.
- `data_out` is held constant while in DRIVE, even if pushes occur.
- `data_oe` falls at the 3rd clk edge after `ior_n` rises; the pop happens on that same edge.
- Push to `empty`=0 takes 1 cycle; a byte pushed is readable by a strobe whose falling edge is synced on the following cycle.
- `level`, `full`, `empty` and `overflow` are registered and update one edge after the causing event.
- Reset asserted mid-read: `data_oe` drops immediately (asynchronously) and the state machine returns to IDLE.
- IOR# pulses shorter than 2 clk periods may be missed; the ISA minimum pulse width at the minimum clk rate guarantees capture.

## Structure
- **Shared `ct2960_pkg`:**
  - port offsets DSP_RDATA=4'hA and DSP_RSTAT=4'hE;
  - STATUS_FILLER=7'h7F;
  - bus state enum {IDLE, DRIVE}.
- **Sub-module `sync_edge`:** 2-flop synchroniser with rise/fall pulse outputs and async active-low `reset` (resets to 1 for IOR#). It is reused later for IOW#.
- **FIFO storage:** a register array inferred inside the block; no separate module.

## Test plan
- **Reset then status read:** IOR# with `sel_status` -> `data_out`=0x7F, `data_oe` high from the 3rd edge to the 3rd edge after release.
- **Push and drain:** push 0xAA, 0x12, 0x34; three data reads -> 0xAA, 0x12, 0x34; `level` 3->0; a status read in between returns 0xFF. A 4th data read returns 0x34 with no pop.
- **Overflow:** push DEPTH+1 bytes (0x00..0x10) -> `full`=1, `overflow`=1, `level`=DEPTH; reads return 0x00..0x0F only.
- **Push with pop:** with `level`=DEPTH, push on the same edge as a read's pop -> `level` stays DEPTH, `overflow` stays 0, and the byte is read last.
- **Flush during read:** `clr_n` pulse while in DRIVE -> `data_out` unchanged until release, no pop, `level`=0, `overflow`=0.
- **Mid-read reset:** drop `reset` in DRIVE -> `data_oe`=0 immediately; after release, `level`=0 and `data_out`=0x00.

Source files
------------

// File: rtl/ct2960_pkg.sv
// Shared CT2960 riser definitions: DSP port offsets, status filler and bus FSM states.
package ct2960_pkg;

    localparam logic [3:0] DSP_RDATA     = 4'hA;
    localparam logic [3:0] DSP_RSTAT     = 4'hE;
    localparam logic [6:0] STATUS_FILLER = 7'h7F;

    typedef enum logic {
        IDLE  = 1'b0,
        DRIVE = 1'b1
    } bus_state_e;

    // Port decode captured when the host strobe is recognised.
    typedef struct packed {
        logic data;
        logic status;
    } cycle_sel_t;

endpackage

// File: rtl/dsp_read_port_if.sv
// Host/DSP-side signal bundle of the DSP read port.
interface dsp_read_port_if #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] wr_data;
    logic             wr_n;
    logic             clr_n;
    logic             ior_n;
    logic             sel_data;
    logic             sel_status;
    logic [WIDTH-1:0] data_out;
    logic             data_oe;
    logic             empty;
    logic             full;
    logic [LW-1:0]    level;
    logic             overflow;

    modport master (
        output wr_data, wr_n, clr_n, ior_n, sel_data, sel_status,
        input  data_out, data_oe, empty, full, level, overflow
    );

    modport slave (
        input  wr_data, wr_n, clr_n, ior_n, sel_data, sel_status,
        output data_out, data_oe, empty, full, level, overflow
    );
endinterface

// File: rtl/sync_edge.sv
// Two-flop synchroniser plus edge detector for an asynchronous strobe (IOR#/IOW#).
module sync_edge #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise_c,
    output logic fall_c
);
    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic s3_q, s3_d;

    // Shift chain: two synchroniser stages followed by the edge-history stage.
    always_comb begin
        s1_d = d;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    // Flops reset to the strobe's idle level so release of reset is not seen as an edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q <= RESET_VAL;
            s2_q <= RESET_VAL;
            s3_q <= RESET_VAL;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign rise_c = s2_q & ~s3_q;
    assign fall_c = ~s2_q & s3_q;
endmodule

// File: rtl/dsp_read_port.sv
// Host read side of the DSP mailbox: byte FIFO from the DSP, returned on ISA data/status reads.
module dsp_read_port
    import ct2960_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input logic            clk,
    input logic            reset,
    dsp_read_port_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic ior_rise_c, ior_fall_c;

    bus_state_e       state_q, state_d;
    cycle_sel_t       cycle_sel_q, cycle_sel_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             data_oe_q, data_oe_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             overflow_q, overflow_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    logic pop_req_c, pop_c, push_c, flush_c;

    sync_edge #(.RESET_VAL(1'b1)) u_ior_sync (
        .clk    (clk),
        .reset  (reset),
        .d      (bus.ior_n),
        .rise_c (ior_rise_c),
        .fall_c (ior_fall_c)
    );

    // Bus FSM: capture the decode and drive value on strobe start, release and request a pop on strobe end.
    always_comb begin
        state_d     = state_q;
        cycle_sel_d = cycle_sel_q;
        data_out_d  = data_out_q;
        data_oe_d   = data_oe_q;
        pop_req_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ior_fall_c) begin
                    state_d     = DRIVE;
                    cycle_sel_d = '{data: bus.sel_data, status: bus.sel_status};
                    data_oe_d   = bus.sel_data | bus.sel_status;
                    if (bus.sel_data) begin
                        data_out_d = empty_q ? last_q : mem_q[rd_ptr_q];
                    end else if (bus.sel_status) begin
                        data_out_d = WIDTH'({~empty_q, STATUS_FILLER});
                    end
                end
            end
            DRIVE: begin
                if (ior_rise_c) begin
                    state_d   = IDLE;
                    data_oe_d = 1'b0;
                    pop_req_c = cycle_sel_q.data;
                end
            end
            default: begin
                state_d   = IDLE;
                data_oe_d = 1'b0;
            end
        endcase
    end

    // FIFO: push/pop/flush bookkeeping; a full FIFO still accepts a push that coincides with a pop.
    always_comb begin
        flush_c    = ~bus.clr_n;
        pop_c      = pop_req_c & ~empty_q;
        push_c     = ~bus.wr_n & (~full_q | pop_c);
        mem_d      = mem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        last_d     = last_q;
        if (flush_c) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            level_d    = '0;
            overflow_d = 1'b0;
            last_d     = '0;
        end else begin
            if (push_c) begin
                mem_d[wr_ptr_q] = bus.wr_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop_c) begin
                last_d   = mem_q[rd_ptr_q];
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            level_d    = level_q + LW'(push_c) - LW'(pop_c);
            overflow_d = overflow_q | (~bus.wr_n & ~push_c);
        end
        empty_d = (level_d == '0);
        full_d  = (level_d == LW'(DEPTH));
    end

    // State and control registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cycle_sel_q <= '0;
            data_out_q  <= '0;
            data_oe_q   <= 1'b0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            level_q     <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            overflow_q  <= 1'b0;
            last_q      <= '0;
        end else begin
            state_q     <= state_d;
            cycle_sel_q <= cycle_sel_d;
            data_out_q  <= data_out_d;
            data_oe_q   <= data_oe_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            level_q     <= level_d;
            empty_q     <= empty_d;
            full_q      <= full_d;
            overflow_q  <= overflow_d;
            last_q      <= last_d;
        end
    end

    // FIFO storage array; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.data_out = data_out_q;
    assign bus.data_oe  = data_oe_q;
    assign bus.empty    = empty_q;
    assign bus.full     = full_q;
    assign bus.level    = level_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_dsp_read_port.sv
// Randomised bench for dsp_read_port with a queue-based model of the mailbox.
module tb_dsp_read_port;
    import ct2960_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned WIDTH = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    dsp_read_port_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

    dsp_read_port #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0] mq[$];
    logic [7:0] m_last;
    logic       m_ovf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        mq.delete();
        m_last = 8'h00;
        m_ovf  = 1'b0;
    endtask

    task automatic model_push(input logic [7:0] b);
        if (mq.size() < DEPTH) mq.push_back(b);
        else m_ovf = 1'b1;
    endtask

    task automatic check_flags(input string tag);
        check({tag, ".level"},    32'(bus.level),    32'(mq.size()));
        check({tag, ".empty"},    32'(bus.empty),    32'(mq.size() == 0));
        check({tag, ".full"},     32'(bus.full),     32'(mq.size() == DEPTH));
        check({tag, ".overflow"}, 32'(bus.overflow), 32'(m_ovf));
    endtask

    task automatic push(input logic [7:0] b);
        bus.wr_data = b;
        bus.wr_n    = 1'b0;
        tick();
        bus.wr_n    = 1'b1;
        model_push(b);
        check_flags("push");
    endtask

    task automatic flush();
        bus.clr_n = 1'b0;
        tick();
        bus.clr_n = 1'b1;
        model_clear();
        check_flags("flush");
    endtask

    // One complete IOR# strobe at the given port offset.
    task automatic host_read(input logic [3:0] offset, input bit push_at_pop,
                             input logic [7:0] pb, input bit flush_mid);
        logic [7:0] exp;
        bit is_data, is_stat, sel;
        is_data = (offset == DSP_RDATA);
        is_stat = (offset == DSP_RSTAT);
        sel     = is_data | is_stat;
        exp     = 8'h00;
        bus.sel_data   = is_data;
        bus.sel_status = is_stat;
        bus.ior_n      = 1'b0;
        tick();
        tick();
        check("rd.oe_before_3rd", 32'(bus.data_oe), 32'(0));
        if (is_data) exp = (mq.size() != 0) ? mq[0] : m_last;
        else if (is_stat) exp = {mq.size() != 0, STATUS_FILLER};
        tick();
        check("rd.oe_at_3rd", 32'(bus.data_oe), 32'(sel));
        if (sel) check("rd.data", 32'(bus.data_out), 32'(exp));
        if (flush_mid) begin
            bus.clr_n = 1'b0;
            tick();
            bus.clr_n = 1'b1;
            model_clear();
            check_flags("rd.flush");
            if (sel) check("rd.data_after_flush", 32'(bus.data_out), 32'(exp));
        end
        repeat ($urandom_range(0, 3)) tick();
        if (sel) check("rd.data_held", 32'(bus.data_out), 32'(exp));
        bus.ior_n = 1'b1;
        tick();
        tick();
        check("rd.oe_before_release", 32'(bus.data_oe), 32'(sel));
        if (push_at_pop) begin
            bus.wr_data = pb;
            bus.wr_n    = 1'b0;
        end
        tick();
        bus.wr_n = 1'b1;
        check("rd.oe_released", 32'(bus.data_oe), 32'(0));
        if (is_data && mq.size() != 0) m_last = mq.pop_front();
        if (push_at_pop) model_push(pb);
        check_flags("rd");
        bus.sel_data   = 1'b0;
        bus.sel_status = 1'b0;
    endtask

    initial begin
        logic [3:0] offs;
        int op;
        bus.wr_data    = 8'h00;
        bus.wr_n       = 1'b1;
        bus.clr_n      = 1'b1;
        bus.ior_n      = 1'b1;
        bus.sel_data   = 1'b0;
        bus.sel_status = 1'b0;
        model_clear();

        // Reset values
        repeat (3) tick();
        check("reset.data_out", 32'(bus.data_out), 32'(8'h00));
        check("reset.data_oe",  32'(bus.data_oe),  32'(0));
        check_flags("reset");
        reset = 1'b1;
        tick();

        // Status read while empty
        host_read(DSP_RSTAT, 1'b0, 8'h00, 1'b0);

        // Push and drain with an interleaved status read and a repeat read
        push(8'hAA);
        push(8'h12);
        push(8'h34);
        check("drain.level3", 32'(bus.level), 32'(3));
        host_read(DSP_RDATA, 1'b0, 8'h00, 1'b0);
        host_read(DSP_RSTAT, 1'b0, 8'h00, 1'b0);
        host_read(DSP_RDATA, 1'b0, 8'h00, 1'b0);
        host_read(DSP_RDATA, 1'b0, 8'h00, 1'b0);
        check("drain.level0", 32'(bus.level), 32'(0));
        host_read(DSP_RDATA, 1'b0, 8'h00, 1'b0);
        check("drain.repeat_last", 32'(bus.data_out), 32'(8'h34));

        // Unselected strobe never drives the bus
        host_read(4'h0, 1'b0, 8'h00, 1'b0);

        // Overflow: DEPTH+1 pushes
        for (int i = 0; i <= DEPTH; i++) push(8'(i));
        check("ovf.full",     32'(bus.full),     32'(1));
        check("ovf.overflow", 32'(bus.overflow), 32'(1));
        for (int i = 0; i < DEPTH; i++) host_read(DSP_RDATA, 1'b0, 8'h00, 1'b0);
        check("ovf.last_byte", 32'(bus.data_out), 32'(8'h0F));
        flush();

        // Push coinciding with a pop while full
        for (int i = 0; i < DEPTH; i++) push(8'($urandom_range(0, 255)));
        host_read(DSP_RDATA, 1'b1, 8'hC5, 1'b0);
        check("pp.level", 32'(bus.level), 32'(DEPTH));
        check("pp.overflow", 32'(bus.overflow), 32'(0));
        for (int i = 0; i < DEPTH; i++) host_read(DSP_RDATA, 1'b0, 8'h00, 1'b0);
        check("pp.read_last", 32'(bus.data_out), 32'(8'hC5));

        // Flush while a data read is in progress
        push(8'h5A);
        push(8'h6B);
        push(8'h7C);
        host_read(DSP_RDATA, 1'b0, 8'h00, 1'b1);
        host_read(DSP_RDATA, 1'b0, 8'h00, 1'b0);

        // Random mix of pushes, reads and occasional flushes
        for (int n = 0; n < 300; n++) begin
            op = int'($urandom_range(0, 19));
            if (op < 9) begin
                push(8'($urandom_range(0, 255)));
            end else if (op < 18) begin
                case ($urandom_range(0, 5))
                    0:       offs = DSP_RSTAT;
                    1:       offs = 4'h0;
                    default: offs = DSP_RDATA;
                endcase
                host_read(offs, ($urandom_range(0, 3) == 0), 8'($urandom_range(0, 255)),
                          ($urandom_range(0, 15) == 0));
            end else if (op == 18) begin
                flush();
            end else begin
                repeat ($urandom_range(1, 3)) tick();
                check_flags("idle");
            end
        end

        // Reset asserted in the middle of a read
        push(8'h99);
        bus.sel_data = 1'b1;
        bus.ior_n    = 1'b0;
        repeat (3) tick();
        check("mrst.oe_before", 32'(bus.data_oe), 32'(1));
        #2;
        reset = 1'b0;
        #1;
        check("mrst.oe_async", 32'(bus.data_oe), 32'(0));
        bus.ior_n    = 1'b1;
        bus.sel_data = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        model_clear();
        tick();
        check("mrst.data_out", 32'(bus.data_out), 32'(8'h00));
        check("mrst.data_oe",  32'(bus.data_oe),  32'(0));
        check_flags("mrst");
        host_read(DSP_RDATA, 1'b0, 8'h00, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
